// File: rtl/tag_sort_pkg.sv
// Shared defaults and legal parameter ranges for the tag-sorting datapath,
// plus a small popcount helper used for stage occupancy.
package tag_sort_pkg;

  localparam int TAG_W_DEF   = 12;
  localparam int NIB_W_DEF   = 4;
  localparam int NUM_BAK_DEF = 2;
  localparam int DEPTH_DEF   = 1;

  localparam int NUM_BAK_MIN = 1;
  localparam int NUM_BAK_MAX = 8;
  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 8;

  function automatic int count_ones(input logic [DEPTH_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH_MAX; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  function automatic bit params_ok(input int num_bak, input int depth);
    return (num_bak >= NUM_BAK_MIN) && (num_bak <= NUM_BAK_MAX) &&
           (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/tag_pipe_stage.sv
// One pipeline slot: a valid bit plus payload register. Loads on accept,
// empties when its entry is taken downstream or on flush, otherwise holds.
module tag_pipe_stage
  import tag_sort_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      // load/unload are already gated off during flush; flush only drops valid
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (unload) begin
        valid <= 1'b0;
      end
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/tag_pipe_reg.sv
// Elastic register pipe for a forward tag plus packed backup tags, with
// bubble collapse, global enable, flush and registered occupancy tracking.
module tag_pipe_reg
  import tag_sort_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NIB_W   = NIB_W_DEF,
  parameter int NUM_BAK = NUM_BAK_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           tag_fwd_in,
  input  logic [NUM_BAK*NIB_W-1:0]   tag_bak_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           tag_fwd_out,
  output logic [NUM_BAK*NIB_W-1:0]   tag_bak_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  // Handshake: an entry moves across a boundary on a rising edge exactly when
  // the sender's valid and the receiver's ready are both high in that cycle
  // with ena=1 and flush=0; valid never depends on ready, ready may depend on
  // valid and is combinational from out_ready back to in_ready.

  localparam int BAK_W = NUM_BAK * NIB_W;
  localparam int PAY_W = TAG_W + BAK_W;
  localparam int OCC_W = $clog2(DEPTH + 1);

  if (!params_ok(NUM_BAK, DEPTH)) begin : g_bad_params
    $error("tag_pipe_reg: NUM_BAK or DEPTH outside supported range");
  end

  logic             go;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] unload;
  logic [PAY_W-1:0] pay [DEPTH+1];

  assign go     = ena & ~flush;
  assign pay[0] = {tag_fwd_in, tag_bak_in};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic src_valid;

    // A stage can accept if it, or any stage after it, has a hole, or the
    // output is draining: every occupied stage ahead then shifts forward.
    assign rdy[i] = ~(&vld[DEPTH-1:i]) | out_ready;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
    end else begin : g_body
      assign src_valid = vld[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign unload[i] = go & vld[i] & out_ready;
    end else begin : g_mid
      assign unload[i] = go & vld[i] & rdy[i+1];
    end

    assign load[i] = go & src_valid & rdy[i];

    tag_pipe_stage #(
      .W(PAY_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (load[i]),
      .unload (unload[i]),
      .d      (pay[i]),
      .valid  (vld[i]),
      .q      (pay[i+1])
    );
  end

  assign in_ready    = go & rdy[0];
  assign out_valid   = vld[DEPTH-1];
  assign tag_fwd_out = pay[DEPTH][PAY_W-1:BAK_W];
  assign tag_bak_out = pay[DEPTH][BAK_W-1:0];
  assign occupancy   = OCC_W'(count_ones(DEPTH_MAX'(vld)));

endmodule

// File: tb/tb_tag_pipe_reg.sv
// Bench for tag_pipe_reg: three depths driven by shared stimulus, each checked
// every cycle against a slot model, plus an in-order scoreboard on DEPTH=3.
module tb_tag_pipe_reg;

  localparam int TW = 12;
  localparam int NW = 4;
  localparam int NB = 3;
  localparam int BW = NW * NB;
  localparam int PW = TW + BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [TW-1:0] tag_fwd_in = '0;
  logic [BW-1:0] tag_bak_in = '0;

  logic [2:0]    in_ready;
  logic [2:0]    out_valid;
  logic [TW-1:0] fwd_o [3];
  logic [BW-1:0] bak_o [3];
  logic [1:0]    occ0;
  logic [1:0]    occ1;
  logic [2:0]    occ2;

  int n_cmp = 0;
  int n_bad = 0;
  int dep [3] = '{2, 3, 4};

  bit            m_v [3][4];
  logic [PW-1:0] m_d [3][4];
  logic [PW-1:0] exp_q [$];
  bit            sb_pop;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  tag_pipe_reg #(.TAG_W(TW), .NIB_W(NW), .NUM_BAK(NB), .DEPTH(2)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .tag_fwd_in(tag_fwd_in), .tag_bak_in(tag_bak_in),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .tag_fwd_out(fwd_o[0]), .tag_bak_out(bak_o[0]), .occupancy(occ0)
  );

  tag_pipe_reg #(.TAG_W(TW), .NIB_W(NW), .NUM_BAK(NB), .DEPTH(3)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .tag_fwd_in(tag_fwd_in), .tag_bak_in(tag_bak_in),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .tag_fwd_out(fwd_o[1]), .tag_bak_out(bak_o[1]), .occupancy(occ1)
  );

  tag_pipe_reg #(.TAG_W(TW), .NIB_W(NW), .NUM_BAK(NB), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[2]),
    .tag_fwd_in(tag_fwd_in), .tag_bak_in(tag_bak_in),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .tag_fwd_out(fwd_o[2]), .tag_bak_out(bak_o[2]), .occupancy(occ2)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic int m_occ(input int k);
    int n;
    n = 0;
    for (int i = 0; i < dep[k]; i++) n += int'(m_v[k][i]);
    return n;
  endfunction

  // Pipe accepts when enabled, not flushing, and either has room or is draining.
  function automatic bit m_in_ready(input int k);
    return ena && !flush && ((m_occ(k) < dep[k]) || out_ready);
  endfunction

  task automatic check_all();
    int d;
    sb_pop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = dep[k];
      check_val($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_v[k][d-1]));
      check_val($sformatf("occupancy[%0d]", k), 32'(occ_of(k)), 32'(m_occ(k)));
      check_val($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(m_in_ready(k)));
      check_val($sformatf("tag_fwd_out[%0d]", k), 32'(fwd_o[k]), 32'(m_d[k][d-1][PW-1:BW]));
      check_val($sformatf("tag_bak_out[%0d]", k), 32'(bak_o[k]), 32'(m_d[k][d-1][BW-1:0]));
    end
    if (!rst && ena && !flush && out_valid[1] && out_ready) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("sb_order", 32'({fwd_o[1], bak_o[1]}), 32'(exp_q[0]));
        sb_pop = 1'b1;
      end
    end
  endtask

  task automatic step_models();
    bit acc [3];
    int d;
    for (int k = 0; k < 3; k++) acc[k] = in_valid && m_in_ready(k);
    for (int k = 0; k < 3; k++) begin
      d = dep[k];
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_v[k][i] = 1'b0;
          m_d[k][i] = '0;
        end
      end else if (flush) begin
        for (int i = 0; i < 4; i++) m_v[k][i] = 1'b0;
      end else if (ena) begin
        if (m_v[k][d-1] && out_ready) m_v[k][d-1] = 1'b0;
        // walk from the output back: each entry advances one slot into a hole
        for (int i = d - 2; i >= 0; i--) begin
          if (m_v[k][i] && !m_v[k][i+1]) begin
            m_v[k][i+1] = 1'b1;
            m_d[k][i+1] = m_d[k][i];
            m_v[k][i]   = 1'b0;
          end
        end
        if (acc[k]) begin
          m_v[k][0] = 1'b1;
          m_d[k][0] = {tag_fwd_in, tag_bak_in};
        end
      end
    end
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (sb_pop) void'(exp_q.pop_front());
      if (acc[1]) exp_q.push_back({tag_fwd_in, tag_bak_in});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    step_models();
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; ena = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready[1]), 32'd1);
    check_val("rst_out_valid", 32'(out_valid[1]), 32'd0);
    check_val("rst_occ", 32'(occ1), 32'd0);
  endtask

  task automatic push(input logic [TW-1:0] f, input logic [BW-1:0] b);
    in_valid = 1'b1; tag_fwd_in = f; tag_bak_in = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        m_v[k][i] = 1'b0;
        m_d[k][i] = '0;
      end

    // Streaming latency and order on DEPTH=3
    reset_all();
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) push(TW'(c + 1), BW'($urandom));
      else in_valid = 1'b0;
      tick();
      check_val("lat_valid", 32'(out_valid[1]), 32'(c >= 2 && c <= 6));
      if (c >= 2 && c <= 6) check_val("lat_tag", 32'(fwd_o[1]), 32'(c - 1));
    end

    // Fill DEPTH=3 with output blocked, then drain-and-fill in one cycle
    reset_all();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      push(TW'('h10 + j), BW'(j));
      #1;
      check_val("fill_in_ready", 32'(in_ready[1]), 32'd1);
      tick();
    end
    push(12'h013, 12'h003);
    #1;
    check_val("full_in_ready", 32'(in_ready[1]), 32'd0);
    check_val("full_occ", 32'(occ1), 32'd3);
    tick();
    out_ready = 1'b1;
    #1;
    check_val("drainfill_in_ready", 32'(in_ready[1]), 32'd1);
    tick();
    check_val("drainfill_occ", 32'(occ1), 32'd3);
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) tick();

    // Enable low freezes a DEPTH=2 pipe holding one entry in stage 0
    reset_all();
    out_ready = 1'b0;
    push(12'h037, 12'h777);
    tick();
    in_valid = 1'b0; ena = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_val("frz_in_ready", 32'(in_ready[0]), 32'd0);
      tick();
      check_val("frz_occ", 32'(occ0), 32'd1);
      check_val("frz_out_valid", 32'(out_valid[0]), 32'd0);
    end
    ena = 1'b1;
    for (int j = 0; j < 3; j++) tick();

    // Flush a full DEPTH=4 pipe: valids drop, payload stays
    reset_all();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      push(TW'('h20 + j), BW'('h100 + j));
      tick();
    end
    check_val("pre_flush_occ", 32'(occ2), 32'd4);
    flush = 1'b1;
    push(12'h099, 12'h999);
    #1;
    check_val("flush_in_ready", 32'(in_ready[2]), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_occ", 32'(occ2), 32'd0);
    check_val("flush_out_valid", 32'(out_valid[2]), 32'd0);
    check_val("flush_fwd_kept", 32'(fwd_o[2]), 32'h020);
    check_val("flush_bak_kept", 32'(bak_o[2]), 32'h100);

    // Reset mid-stream discards the in-flight entry
    reset_all();
    out_ready = 1'b1;
    push(12'h039, 12'hABC);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("midrst_fwd", 32'(fwd_o[1]), 32'd0);
    check_val("midrst_bak", 32'(bak_o[1]), 32'd0);
    check_val("midrst_occ", 32'(occ1), 32'd0);
    for (int j = 0; j < 6; j++) begin
      tick();
      check_val("midrst_no_emerge", 32'(out_valid[1] | out_valid[2]), 32'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tag_fwd_in = TW'($urandom);
      tag_bak_in = BW'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_pipe_reg.md
TAG_PIPE_REG -- requirements
Module: tag_pipe_reg

Interface
REQ-001 SHALL have parameter TAG_W, default 12, forward-tag width.
REQ-002 SHALL have parameter NIB_W, default 4, width of each backup tag.
REQ-003 SHALL have parameter NUM_BAK, default 2, backup-tag channel count (1..8).
REQ-004 SHALL have parameter DEPTH, default 1, register stage count (1..8).
REQ-005 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port ena, input, 1, global enable; 0 freezes the pipe.
REQ-008 SHALL have port flush, input, 1, discards all held entries.
REQ-009 SHALL have port in_valid, input, 1, upstream entry present.
REQ-010 SHALL have port in_ready, output, 1, entry accepted this cycle when in_valid=1.
REQ-011 SHALL have port tag_fwd_in, input, TAG_W, forward tag.
REQ-012 SHALL have port tag_bak_in, input, NUM_BAK*NIB_W, packed backup tags, channel 0 in LSBs.
REQ-013 SHALL have port out_valid, output, 1, final stage holds an entry.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts.
REQ-015 SHALL have port tag_fwd_out, output, TAG_W, final-stage forward tag.
REQ-016 SHALL have port tag_bak_out, output, NUM_BAK*NIB_W, final-stage backup tags.
REQ-017 SHALL have port occupancy, output, clog2(DEPTH+1), count of valid stages.

Function
REQ-018 Stage i SHALL be ready when it is empty or stage i+1 (or out_ready for the last stage) takes its entry the same cycle.
REQ-019 in_ready SHALL equal ena AND !flush AND stage-0 ready; the ready chain is combinational.
REQ-020 Stage i SHALL load when its predecessor presents a valid entry and stage i is ready, ena=1 and flush=0.
REQ-021 Empty stages SHALL be filled by advancing entries (bubble collapse); order SHALL be preserved.
REQ-022 Latency from in_valid&&in_ready to out_valid SHALL be DEPTH cycles with no stall; throughput one entry per cycle.
REQ-023 Data registers SHALL load only on accept; a stage not loading SHALL hold its data.
REQ-024 Outputs tag_fwd_out and tag_bak_out SHALL show final-stage data whether or not out_valid=1.
REQ-025 With ena=0, all valid and data bits SHALL hold, in_ready=0, and out_valid SHALL keep its value; no transfer is counted even if out_ready=1.
REQ-026 flush=1 SHALL clear every valid bit on the next edge, regardless of ena; data SHALL be retained.
REQ-027 During flush, an entry presented on the output that cycle SHALL NOT be counted as transferred downstream.
REQ-028 occupancy SHALL equal the number of set valid bits, updated registered with them; full when occupancy=DEPTH.
REQ-029 When full and out_ready=1, in_ready SHALL be 1 (simultaneous drain and fill, occupancy unchanged).

Reset
REQ-030 rst=1 SHALL on the next edge clear all valid bits and all tag data to zero, overriding ena and flush.
REQ-031 After reset: out_valid=0, occupancy=0, tag_fwd_out=0, tag_bak_out=0, in_ready=ena.
REQ-032 Reset asserted mid-stream SHALL discard all entries; no partial entry SHALL appear after release.

Structure
REQ-033 Default TAG_W, NIB_W, NUM_BAK and the bounds check constants SHALL live in the shared package tag_sort_pkg.
REQ-034 One slot (valid bit plus payload, load/hold/clear) SHALL be the sub-module tag_pipe_stage, instantiated DEPTH times via generate.

Verification
REQ-035 DEPTH=3, out_ready=1, stream tags 0x001..0x005 back-to-back -> 0x001 out_valid 3 cycles after accept, then one per cycle, in order.
REQ-036 DEPTH=3, out_ready=0, push 4 entries -> 3 accepted, in_ready=0 on 4th, occupancy=3; out_ready=1 one cycle -> 4th accepted same cycle, occupancy stays 3.
REQ-037 DEPTH=2, entry in stage 0 with out_ready=0, then ena=0 for 5 cycles with out_ready=1 -> no movement, occupancy held, in_ready=0.
REQ-038 DEPTH=4 full, flush=1 with in_valid=1 -> in_ready=0, next cycle occupancy=0, out_valid=0, payload regs unchanged.
REQ-039 NUM_BAK=3, NIB_W=4, tag_bak_in=0xABC, rst pulsed while entry in flight -> after rst all outputs 0, entry never emerges.
